// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M-style multiply/divide unit with valid/ready handshake
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   kill_i        synchronous abort of the in-flight operation
//   in_valid_i    operands/funct3_i valid; in_ready_o unit can accept
//   funct3_i      0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   op1_i, op2_i  rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   out_valid_o   result_o valid; out_ready_i consumer accepts
//   busy_o        operation in flight or result pending
module alu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  kill_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  busy_o
);
  localparam int W = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [W-1:0] b_q, b_d, lo_q, lo_d, acc_q, acc_d, res_q, res_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d, rneg_q, rneg_d;
  logic accept, s1, s2, dz, ovf, nob, is_div;
  logic [W-1:0] m1, m2, spec_res, step_acc, step_lo, quo_s, rem_s, fin;
  logic [W:0] msum, dshift;
  logic [W+1:0] ddiff;
  logic [2*W-1:0] prod, prod_s;
  assign in_ready_o  = (state_q == IDLE) & ~kill_i;
  assign out_valid_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign result_o    = res_q;
  assign accept      = in_valid_i & in_ready_o;
  // operand signedness: MULH/DIV/REM both, MULHSU rs1 only
  assign s1 = op1_i[W-1] & ((funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i[2] & ~funct3_i[0]));
  assign s2 = op2_i[W-1] & ((funct3_i == 3'd1) | (funct3_i[2] & ~funct3_i[0]));
  assign m1 = s1 ? -op1_i : op1_i;
  assign m2 = s2 ? -op2_i : op2_i;
  assign dz  = funct3_i[2] & (op2_i == '0);
  assign ovf = funct3_i[2] & ~funct3_i[0] & (op1_i == {1'b1, {(W-1){1'b0}}}) & (&op2_i);
  assign spec_res = funct3_i[1] ? (dz ? op1_i : '0) : (dz ? '1 : op1_i);
  // multiply step: {acc,lo} is the 2W product register, multiplier shifts out of lo
  assign msum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  // divide step: shift next dividend bit into the W+1 bit partial remainder, trial subtract
  assign dshift = {acc_q, lo_q[W-1]};
  assign ddiff  = {1'b0, dshift} - {2'b0, b_q};
  assign nob    = ~ddiff[W+1];
  assign is_div = op_q[2];
  assign step_acc = is_div ? (nob ? ddiff[W-1:0] : dshift[W-1:0]) : msum[W:1];
  assign step_lo  = is_div ? {lo_q[W-2:0], nob} : {msum[0], lo_q[W-1:1]};
  assign prod   = {step_acc, step_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo_s  = neg_q ? -step_lo : step_lo;
  assign rem_s  = rneg_q ? -step_acc : step_acc;
  assign fin = is_div ? (op_q[1] ? rem_s : quo_s) : ((op_q == 3'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W]);
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    if (kill_i && state_q != IDLE) begin
      state_d = IDLE;
    end else if (state_q == IDLE && accept) begin
      op_d    = funct3_i;
      neg_d   = s1 ^ s2;
      rneg_d  = s1;
      acc_d   = '0;
      cnt_d   = CNT_WIDTH'(W);
      b_d     = funct3_i[2] ? m2 : m1;
      lo_d    = funct3_i[2] ? m1 : m2;
      state_d = (dz | ovf) ? DONE : CALC;
      res_d   = (dz | ovf) ? spec_res : res_q;
    end else if (state_q == CALC) begin
      acc_d = step_acc;
      lo_d  = step_lo;
      cnt_d = cnt_q - CNT_WIDTH'(1);
      if (cnt_q == CNT_WIDTH'(1)) begin
        res_d   = fin;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready_i) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
    end
  end
endmodule
